// File: rtl/bus_slave_responder.sv
// Serial bus slave: shifts in an address LSB first, then either writes a data word
// into local memory or returns a memory word serially after a fixed wait.
module bus_slave_responder #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int MEM_AW   = 11,
    parameter int READ_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic m_valid,
    input  logic m_mode,
    input  logic m_wdata,
    output logic s_rdata,
    output logic s_rvalid,
    output logic s_ready,
    output logic s_busy
);

    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ((ADDR_W > READ_LAT) ? ADDR_W : READ_LAT)
                                               : ((DATA_W > READ_LAT) ? DATA_W : READ_LAT);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'((64'd1 << MEM_AW) - 64'd1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WAIT, RDATA, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                isWrite_q;

    logic [DATA_W-1:0]   mem [2**MEM_AW];

    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [ADDR_W-1:0]   rdAddr;
    logic [DATA_W-1:0]   rdWord;
    logic                lastAddrBit;
    logic                lastDataBit;
    logic                memWe;

    function automatic logic inRange(input logic [ADDR_W-1:0] a);
        return (a & HI_MASK) == '0;
    endfunction

    // With zero read latency the word is fetched while the last address bit is still on the wire
    always_comb begin
        addr_d      = {m_wdata, addr_q[ADDR_W-1:1]};
        wdata_d     = {m_wdata, data_q[DATA_W-1:1]};
        lastAddrBit = (cnt_q == CW'(ADDR_W - 1));
        lastDataBit = (cnt_q == CW'(DATA_W - 1));
        rdAddr      = (READ_LAT == 0) ? addr_d : addr_q;
        rdWord      = inRange(rdAddr) ? mem[rdAddr[MEM_AW-1:0]] : '0;
        memWe       = !rst && m_valid && (state_q == WDATA) && lastDataBit && inRange(addr_q);
    end

    always_ff @(posedge clk) begin
        if (memWe)
            mem[addr_q[MEM_AW-1:0]] <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            isWrite_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_valid) begin
                        isWrite_q <= m_mode;
                        addr_q    <= addr_d;
                        cnt_q     <= CW'(1);
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (!m_valid) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        addr_q <= addr_d;
                        if (lastAddrBit) begin
                            cnt_q <= '0;
                            if (isWrite_q)
                                state_q <= WDATA;
                            else if (READ_LAT == 0) begin
                                data_q  <= rdWord;
                                state_q <= RDATA;
                            end else
                                state_q <= WAIT;
                        end else
                            cnt_q <= cnt_q + CW'(1);
                    end
                end
                WDATA: begin
                    if (!m_valid) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        data_q <= wdata_d;
                        if (lastDataBit) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else
                            cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT: begin
                    if (!m_valid) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == CW'(READ_LAT - 1)) begin
                        data_q  <= rdWord;
                        cnt_q   <= '0;
                        state_q <= RDATA;
                    end else
                        cnt_q <= cnt_q + CW'(1);
                end
                RDATA: begin
                    if (!m_valid) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        data_q <= data_q >> 1;
                        if (lastDataBit) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else
                            cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_rvalid = (state_q == RDATA);
    assign s_rdata  = s_rvalid & data_q[0];
    assign s_ready  = (state_q == DONE);
    assign s_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bus_slave_responder.sv
// Self-checking bench for bus_slave_responder: directed scenarios plus randomized
// transactions compared cycle by cycle against a transaction-level memory model.
module tb_bus_slave_responder;

    logic clk;
    logic rst;
    logic m_valid;
    logic m_mode;
    logic m_wdata;
    logic s_rdata;
    logic s_rvalid;
    logic s_ready;
    logic s_busy;

    int checks;
    int errors;

    logic [7:0] modelMem [2048];

    bus_slave_responder dut (
        .clk      (clk),
        .rst      (rst),
        .m_valid  (m_valid),
        .m_mode   (m_mode),
        .m_wdata  (m_wdata),
        .s_rdata  (s_rdata),
        .s_rvalid (s_rvalid),
        .s_ready  (s_ready),
        .s_busy   (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, act, exp);
        end
    endtask

    // One transaction seen from the initiator: write = 12 address + 8 data cycles then
    // DONE, read = 12 address + 2 wait + 8 data cycles then DONE. cutAt >= 0 interrupts
    // the transaction in that cycle by dropping m_valid or by pulsing rst.
    task automatic applyStimulus(input bit isWr, input logic [11:0] addr, input logic [7:0] wd,
                                 input int cutAt, input bit cutRst, input bit holdValid,
                                 input string name);
        int total;
        int last;
        logic [7:0] word;
        logic [7:0] expV;
        logic [7:0] actV;
        bit inRange;
        bit rv;
        total   = isWr ? 20 : 22;
        inRange = (addr < 12'd2048);
        word    = inRange ? modelMem[addr[10:0]] : 8'h00;
        last    = (cutAt >= 0) ? cutAt + 1 : total;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (cutAt >= 0 && i == cutAt + 1)
                expV = 8'h00;
            else begin
                rv   = !isWr && i >= 14 && i <= 21;
                expV = {4'b0, (i >= 1), rv, (rv ? word[i-14] : 1'b0), (i == total)};
            end
            actV = {4'b0, s_busy, s_rvalid, s_rdata, s_ready};
            checkOutput($sformatf("%s cyc%0d {busy,rvalid,rdata,ready}", name, i), actV, expV);
            if (cutAt >= 0 && i == cutAt) begin
                if (cutRst) rst = 1'b1;
                else        m_valid = 1'b0;
            end else if (cutAt >= 0 && i == last) begin
                rst     = 1'b0;
                m_valid = 1'b0;
            end else if (i < total) begin
                m_valid = 1'b1;
                m_mode  = (i == 0) ? isWr : 1'($urandom_range(0, 1));
                if (i < 12)              m_wdata = addr[i];
                else if (isWr && i < 20) m_wdata = wd[i-12];
                else                     m_wdata = 1'($urandom_range(0, 1));
            end else begin
                m_valid = holdValid;
                m_mode  = 1'($urandom_range(0, 1));
                m_wdata = 1'($urandom_range(0, 1));
            end
        end
        if (cutAt < 0 && isWr && inRange)
            modelMem[addr[10:0]] = wd;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_valid = 1'b0;
        end
    endtask

    logic [11:0] pool [8];

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        m_valid = 1'b0;
        m_mode  = 1'b0;
        m_wdata = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset outputs", {4'b0, s_busy, s_rvalid, s_rdata, s_ready}, 8'h00);
        m_valid = 1'b1;
        @(negedge clk);
        checkOutput("reset beats m_valid", {4'b0, s_busy, s_rvalid, s_rdata, s_ready}, 8'h00);
        rst     = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle after reset", {4'b0, s_busy, s_rvalid, s_rdata, s_ready}, 8'h00);

        // Basic write then read, including out-of-range handling and aborts
        applyStimulus(1'b1, 12'h005, 8'hA5, -1, 1'b0, 1'b0, "wr005");
        applyStimulus(1'b0, 12'h005, 8'h00, -1, 1'b0, 1'b0, "rd005");
        applyStimulus(1'b1, 12'h805, 8'h3C, -1, 1'b0, 1'b0, "wr805");
        applyStimulus(1'b0, 12'h805, 8'h00, -1, 1'b0, 1'b0, "rd805");
        applyStimulus(1'b0, 12'h005, 8'h00, -1, 1'b0, 1'b0, "rd005b");
        applyStimulus(1'b1, 12'h010, 8'h11, -1, 1'b0, 1'b0, "wr010");
        applyStimulus(1'b1, 12'h010, 8'h77, 15, 1'b0, 1'b0, "wr010abort");
        applyStimulus(1'b0, 12'h010, 8'h00, -1, 1'b0, 1'b0, "rd010");
        applyStimulus(1'b0, 12'h005, 8'h00, 16, 1'b1, 1'b0, "rd005rst");
        applyStimulus(1'b1, 12'h005, 8'hFF, 19, 1'b1, 1'b0, "wr005rstlast");
        applyStimulus(1'b0, 12'h005, 8'h00, -1, 1'b0, 1'b1, "b2b1");
        applyStimulus(1'b0, 12'h010, 8'h00, -1, 1'b0, 1'b0, "b2b2");
        idleCycles(2);

        // Random traffic over a small address pool, some of it out of range
        for (int k = 0; k < 8; k++) begin
            pool[k] = (k < 6) ? 12'($urandom_range(0, 2047)) : 12'($urandom_range(2048, 4095));
            applyStimulus(1'b1, pool[k], 8'($urandom), -1, 1'b0, 1'b0, $sformatf("init%0d", k));
        end
        for (int k = 0; k < 40; k++) begin
            bit wr;
            bit hold;
            int cut;
            wr   = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            cut  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, wr ? 19 : 21)) : -1;
            applyStimulus(wr, pool[$urandom_range(0, 7)], 8'($urandom), cut,
                          1'($urandom_range(0, 1)), hold, $sformatf("rnd%0d", k));
            if (!hold || cut >= 0)
                idleCycles(int'($urandom_range(0, 2)));
        end
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_slave_responder.md
BUS_SLAVE_RESPONDER -- requirements
Module: bus_slave_responder

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the serial address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the serial data width in bits.
REQ-003 The block SHALL have parameter MEM_AW, default 11, giving the local memory address width (2^MEM_AW words of DATA_W bits).
REQ-004 The block SHALL have parameter READ_LAT, default 2, giving the number of wait cycles between the last address bit and the first read-data bit (range 0..15).

Interface
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 m_valid  in  1  initiator holds high for the whole transaction.
REQ-008 m_mode  in  1  1 = write, 0 = read; sampled only on the start cycle.
REQ-009 m_wdata  in  1  serial address then write data, LSB first.
REQ-010 s_rdata  out  1  serial read data, LSB first.
REQ-011 s_rvalid  out  1  high exactly while s_rdata carries a valid bit.
REQ-012 s_ready  out  1  one-cycle completion pulse.
REQ-013 s_busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 The state machine SHALL have the states IDLE, ADDR, WDATA, WAIT, RDATA and DONE.
REQ-015 Start cycle: in IDLE, with m_valid=1, the block SHALL latch m_mode, take m_wdata as address bit 0, and go to ADDR.
REQ-016 ADDR SHALL shift in the next ADDR_W-1 bits, one per cycle, LSB first; its bit counter SHALL count 1..ADDR_W-1.
REQ-017 After the last address bit, a write SHALL go to WDATA; a read SHALL go to WAIT, or directly to RDATA if READ_LAT=0.
REQ-018 WDATA SHALL shift in DATA_W bits, LSB first.
REQ-019 In the cycle the final data bit is sampled, the block SHALL write the assembled word to mem[addr[MEM_AW-1:0]] and go to DONE.
REQ-020 WAIT SHALL last exactly READ_LAT cycles.
REQ-021 The memory word SHALL be captured into the shift register on the cycle WAIT exits (or on the last address cycle if READ_LAT=0).
REQ-022 RDATA SHALL drive s_rvalid=1 for exactly DATA_W consecutive cycles, with s_rdata = word bit i in the i-th cycle, then go to DONE.
REQ-023 DONE SHALL assert s_ready=1 for one cycle and return to IDLE.
REQ-024 A new start SHALL be accepted no earlier than the cycle after DONE; if m_valid is still high then, it is a new transaction.
REQ-025 Out-of-range address (any addr bit at MEM_AW or above set): writes SHALL be discarded, reads SHALL return all zeros, and the timing and s_ready SHALL be unchanged.
REQ-026 Abort: m_valid=0 in ADDR, WDATA, WAIT or RDATA SHALL return the block to IDLE on the next edge with no memory write and no s_ready; s_rvalid SHALL drop in that same edge.
REQ-027 s_rdata SHALL be 0 whenever s_rvalid=0.
REQ-028 Total latency, write: ADDR_W+DATA_W cycles from the start cycle to DONE.
REQ-029 Total latency, read: ADDR_W+READ_LAT+DATA_W cycles from the start cycle to DONE.
REQ-030 Memory SHALL be inferable as single-port synchronous RAM; its contents are not reset.

Reset
REQ-031 rst=1 SHALL force state=IDLE and clear all counters and shift registers.
REQ-032 During and after rst, the outputs SHALL be s_rdata=0, s_rvalid=0, s_ready=0, s_busy=0.
REQ-033 rst asserted mid-transaction SHALL abort it with no memory write, and SHALL take priority over m_valid.
REQ-034 Memory contents SHALL persist across rst.

Verification
REQ-035 Write at addr 0x005, data 0xA5 -> s_ready pulses at start+20 cycles; s_busy high throughout, low after.
REQ-036 Read at addr 0x005 after REQ-035 -> s_rvalid high for 8 cycles starting at start+14, bits 1,0,1,0,0,1,0,1; s_ready at start+22.
REQ-037 Write 0x3C to addr 0x805 (out of range), then read 0x805 -> read returns 0x00; a read of 0x005 still returns 0xA5.
REQ-038 Write 0x77 to 0x010 with m_valid dropped after 3 data bits -> return to IDLE, no s_ready; a read of 0x010 returns the prior contents.
REQ-039 rst pulsed during RDATA -> s_rvalid=0 and s_busy=0 next cycle; a subsequent read of 0x005 returns 0xA5.
REQ-040 Back-to-back: m_valid held high across DONE with a second read -> second start accepted the cycle after s_ready; both reads return correct data.
